// File: rtl/ibex_pkg.sv
// ibex_pkg: CSR numbers, CSR block offsets and limits shared by the
// performance-counter unit and the counter slice it instantiates.
// No ports.
package ibex_pkg;

   // CSR numbers touched by the counter unit
   typedef enum logic [11:0] {
      CSR_MCOUNTINHIBIT = 12'h320,
      CSR_MHPMEVENT3    = 12'h323,
      CSR_MHPMEVENT31   = 12'h33F,
      CSR_MHPMOVF       = 12'h7C2,
      CSR_MCYCLE        = 12'hB00,
      CSR_MINSTRET      = 12'hB02,
      CSR_MHPMCOUNTER3  = 12'hB03,
      CSR_MCYCLEH       = 12'hB80,
      CSR_MINSTRETH     = 12'hB82,
      CSR_MHPMCOUNTER3H = 12'hB83
   } csr_num_e;

   // Base addresses of the 32-entry counter / event CSR blocks
   localparam logic [11:0] CSR_OFF_MHPMCOUNTER  = 12'hB00;
   localparam logic [11:0] CSR_OFF_MHPMCOUNTERH = 12'hB80;
   localparam logic [11:0] CSR_OFF_MHPMEVENT    = 12'h320;

   localparam int unsigned MAX_HPM_COUNTERS = 29;
   localparam int unsigned NUM_CSR_SLOTS    = 32;

   // Bit mask of implemented counter slots: mcycle (0), minstret (2) and
   // mhpmcounter3 .. mhpmcounter(2+num_counters). Slot 1 (time) is never ours.
   function automatic logic [31:0] hpm_impl_mask(input int unsigned num_counters);
      return 32'h5 | (((32'd1 << num_counters) - 32'd1) << 3);
   endfunction

endpackage

// File: rtl/ibex_counter.sv
// ibex_counter: one machine counter of CounterWidth bits presented as a
// 64-bit low/high CSR pair.
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   counter_inc_i       add one this cycle
//   counter_we_i        write bits [31:0] with counter_val_i
//   counterh_we_i       write bits [63:32] with counter_val_i
//   counter_val_i       CSR write data
//   counter_val_o       current value, zero-extended to 64 bits
//   counter_wrap_c_o    combinational: this cycle's increment wraps to zero
module ibex_counter #(
   parameter int unsigned CounterWidth = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        counter_inc_i,
   input  logic        counter_we_i,
   input  logic        counterh_we_i,
   input  logic [31:0] counter_val_i,
   output logic [63:0] counter_val_o,
   output logic        counter_wrap_c_o
);

   logic [CounterWidth-1:0] counter_q;
   logic [CounterWidth-1:0] counter_d;
   logic [63:0]             counter_ext;
   logic [63:0]             counter_upd;

   assign counter_ext = 64'(counter_q);

   // Work on the 64-bit view so half writes keep the other half, then
   // truncate; bits above CounterWidth are dropped on the way back.
   always_comb begin
      counter_upd      = counter_ext;
      counter_wrap_c_o = 1'b0;
      if (counter_we_i) begin
         counter_upd[31:0] = counter_val_i;
      end else if (counterh_we_i) begin
         counter_upd[63:32] = counter_val_i;
      end else if (counter_inc_i) begin
         counter_upd      = counter_ext + 64'd1;
         counter_wrap_c_o = &counter_q;
      end
      counter_d = CounterWidth'(counter_upd);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         counter_q <= '0;
      end else begin
         counter_q <= counter_d;
      end
   end

   assign counter_val_o = counter_ext;

endmodule

// File: rtl/ibex_hpm_counters.sv
// ibex_hpm_counters: mcycle, minstret, mhpmcounter3.. with mhpmevent
// selects, mcountinhibit and optional overflow interrupt.
// Optional feature macro: IBEX_HPM_OVF_IRQ_EN (sticky overflow bits in
// mhpmovf 0x7C2, W1C, and irq_ovf_o). Undefined: 0x7C2 not decoded, irq tied 0.
// Ports:
//   clk_i, rst_i    clock, async active-high reset
//   csr_we_i        CSR write strobe (already qualified)
//   csr_addr_i      CSR address
//   csr_wdata_i     final CSR write data
//   csr_hit_o       address lies in this unit's CSR range
//   csr_rdata_o     combinational read data for csr_addr_i
//   instr_ret_i     one instruction retired this cycle
//   event_i         per-cycle event pulses
//   irq_ovf_o       counter overflow interrupt (registered)
module ibex_hpm_counters
   import ibex_pkg::*;
#(
   parameter int unsigned NumCounters  = 10,
   parameter int unsigned CounterWidth = 40,
   parameter int unsigned NumEvents    = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 csr_we_i,
   input  logic [11:0]          csr_addr_i,
   input  logic [31:0]          csr_wdata_i,
   output logic                 csr_hit_o,
   output logic [31:0]          csr_rdata_o,
   input  logic                 instr_ret_i,
   input  logic [NumEvents-1:0] event_i,
   output logic                 irq_ovf_o
);

   localparam logic [31:0] ImplMask = hpm_impl_mask(NumCounters);

   logic [4:0]           csr_idx;
   logic                 lo_sel;
   logic                 hi_sel;
   logic                 evt_sel;
   logic                 inh_sel;

   logic [NumEvents-1:0] event_q;
   logic                 instr_ret_q;
   logic [31:0]          inhibit_q;
   logic [31:0]          inhibit_d;

   logic [63:0]          cnt_val   [NUM_CSR_SLOTS];
   logic [NumEvents-1:0] mhpmevent [NUM_CSR_SLOTS];
   logic [31:0]          wrap_c;

   // Address decode
   assign csr_idx = csr_addr_i[4:0];
   assign lo_sel  = (csr_addr_i[11:5] == CSR_OFF_MHPMCOUNTER[11:5]);
   assign hi_sel  = (csr_addr_i[11:5] == CSR_OFF_MHPMCOUNTERH[11:5]);
   assign evt_sel = (csr_addr_i[11:5] == CSR_OFF_MHPMEVENT[11:5]);
   assign inh_sel = (csr_addr_i == CSR_MCOUNTINHIBIT);

   // Unimplemented inhibit bits (including time, bit 1) stay zero
   always_comb begin
      inhibit_d = inhibit_q;
      if (csr_we_i && inh_sel) begin
         inhibit_d = csr_wdata_i & ImplMask;
      end
   end

   // Event/retire stage; a write to mcountinhibit applies from next cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         event_q     <= '0;
         instr_ret_q <= 1'b0;
         inhibit_q   <= '0;
      end else begin
         event_q     <= event_i;
         instr_ret_q <= instr_ret_i;
         inhibit_q   <= inhibit_d;
      end
   end

   // One counter per implemented slot; other slots read as zero
   for (genvar i = 0; i < NUM_CSR_SLOTS; i++) begin : g_slot
      if (i == 0 || i == 2 || (i >= 3 && i < 3 + NumCounters)) begin : g_impl
         localparam int unsigned Width = (i >= 3) ? CounterWidth : 64;

         logic src;
         logic inc;
         logic lo_we;
         logic hi_we;

         if (i == 0) begin : g_cycle
            assign src          = 1'b1;
            assign mhpmevent[i] = '0;
         end else if (i == 2) begin : g_instret
            assign src          = instr_ret_q;
            assign mhpmevent[i] = '0;
         end else begin : g_hpm
            logic [NumEvents-1:0] mhpmevent_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
               if (rst_i) begin
                  mhpmevent_q <= '0;
               end else if (csr_we_i && evt_sel && (csr_idx == 5'(i))) begin
                  mhpmevent_q <= csr_wdata_i[NumEvents-1:0];
               end
            end

            // Any selected event counts once, however many fire together
            assign src          = |(mhpmevent_q & event_q);
            assign mhpmevent[i] = mhpmevent_q;
         end

         assign inc   = ~inhibit_q[i] & src;
         assign lo_we = csr_we_i & lo_sel & (csr_idx == 5'(i));
         assign hi_we = csr_we_i & hi_sel & (csr_idx == 5'(i));

         ibex_counter #(
            .CounterWidth (Width)
         ) u_counter (
            .clk_i            (clk_i),
            .rst_i            (rst_i),
            .counter_inc_i    (inc),
            .counter_we_i     (lo_we),
            .counterh_we_i    (hi_we),
            .counter_val_i    (csr_wdata_i),
            .counter_val_o    (cnt_val[i]),
            .counter_wrap_c_o (wrap_c[i])
         );
      end else begin : g_unimpl
         assign cnt_val[i]   = '0;
         assign mhpmevent[i] = '0;
         assign wrap_c[i]    = 1'b0;
      end
   end

`ifdef IBEX_HPM_OVF_IRQ_EN
   logic [31:0] ovf_q;
   logic [31:0] ovf_d;
   logic        irq_ovf_q;

   // Sticky overflow; a wrap in the same cycle as its W1C keeps the bit set
   always_comb begin
      ovf_d = ovf_q;
      if (csr_we_i && (csr_addr_i == CSR_MHPMOVF)) begin
         ovf_d = ovf_d & ~csr_wdata_i;
      end
      ovf_d = ovf_d | wrap_c;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_q     <= '0;
         irq_ovf_q <= 1'b0;
      end else begin
         ovf_q     <= ovf_d;
         irq_ovf_q <= |ovf_q;
      end
   end

   assign irq_ovf_o = irq_ovf_q;
`else
   logic unused_wrap;
   assign unused_wrap = ^wrap_c;
   assign irq_ovf_o   = 1'b0;
`endif

   // Read mux; unimplemented slots in the range hit and return zero
   always_comb begin
      csr_hit_o   = 1'b0;
      csr_rdata_o = '0;
      if (lo_sel || hi_sel) begin
         csr_hit_o   = (csr_idx != 5'd1);
         csr_rdata_o = lo_sel ? cnt_val[csr_idx][31:0] : cnt_val[csr_idx][63:32];
      end else if (evt_sel) begin
         if (csr_idx == 5'd0) begin
            csr_hit_o   = 1'b1;
            csr_rdata_o = inhibit_q;
         end else if (csr_idx >= 5'd3) begin
            csr_hit_o   = 1'b1;
            csr_rdata_o = 32'(mhpmevent[csr_idx]);
         end
      end
`ifdef IBEX_HPM_OVF_IRQ_EN
      if (csr_addr_i == CSR_MHPMOVF) begin
         csr_hit_o   = 1'b1;
         csr_rdata_o = ovf_q;
      end
`endif
   end

endmodule

// File: tb/tb_ibex_hpm_counters.sv
module tb_ibex_hpm_counters;

   localparam int unsigned NC = 4;
   localparam int unsigned CW = 40;
   localparam int unsigned NE = 16;
`ifdef IBEX_HPM_OVF_IRQ_EN
   localparam bit OvfEn = 1'b1;
`else
   localparam bit OvfEn = 1'b0;
`endif

   localparam logic [11:0] ADDRS [26] = '{
      12'hB00, 12'hB80, 12'hB01, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB04,
      12'hB84, 12'hB05, 12'hB06, 12'hB86, 12'hB07, 12'hB87, 12'hB9F, 12'h320,
      12'h321, 12'h323, 12'h324, 12'h326, 12'h327, 12'h33F, 12'h7C2, 12'h7C2,
      12'h000, 12'hB1F};

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          csr_we_i = 1'b0;
   logic [11:0]   csr_addr_i = '0;
   logic [31:0]   csr_wdata_i = '0;
   logic          instr_ret_i = 1'b0;
   logic [NE-1:0] event_i = '0;
   logic          csr_hit_o;
   logic [31:0]   csr_rdata_o;
   logic          irq_ovf_o;

   always #5 clk_i = ~clk_i;

   ibex_hpm_counters #(
      .NumCounters  (NC),
      .CounterWidth (CW),
      .NumEvents    (NE)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .csr_we_i    (csr_we_i),
      .csr_addr_i  (csr_addr_i),
      .csr_wdata_i (csr_wdata_i),
      .csr_hit_o   (csr_hit_o),
      .csr_rdata_o (csr_rdata_o),
      .instr_ret_i (instr_ret_i),
      .event_i     (event_i),
      .irq_ovf_o   (irq_ovf_o)
   );

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
      logic        hit;
      logic        irq;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   chk_v  = 1'b0;

   // Reference model: architectural state only
   logic [63:0]   m_cnt [32];
   logic [NE-1:0] m_evt [32];
   logic [31:0]   m_inh;
   logic [31:0]   m_ovf;
   logic          m_irq;
   logic          m_retq;
   logic [NE-1:0] m_evq;

   function automatic bit impl(input int i);
      return (i == 0) || (i == 2) || (i >= 3 && i < 3 + int'(NC));
   endfunction

   function automatic logic [63:0] wmask(input int i);
      if (i < 3 || CW == 64) return '1;
      return (64'd1 << CW) - 64'd1;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         m_cnt[i] = '0;
         m_evt[i] = '0;
      end
      m_inh  = '0;
      m_ovf  = '0;
      m_irq  = 1'b0;
      m_retq = 1'b0;
      m_evq  = '0;
   endfunction

   function automatic void exp_read(input logic [11:0] a, output logic [31:0] d, output logic h);
      int idx;
      idx = int'(a[4:0]);
      d = '0;
      h = 1'b0;
      if ((a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F)) begin
         if (idx != 1) begin
            h = 1'b1;
            d = (a >= 12'hB80) ? m_cnt[idx][63:32] : m_cnt[idx][31:0];
         end
      end else if (a == 12'h320) begin
         h = 1'b1;
         d = m_inh;
      end else if (a >= 12'h323 && a <= 12'h33F) begin
         h = 1'b1;
         d = 32'(m_evt[idx]);
      end else if (a == 12'h7C2 && OvfEn) begin
         h = 1'b1;
         d = m_ovf;
      end
   endfunction

   function automatic void model_step(input bit rst, input bit we, input logic [11:0] a,
                                      input logic [31:0] wd, input bit ret, input logic [NE-1:0] ev);
      logic [31:0] wrap;
      logic [31:0] imask;
      logic [63:0] v;
      bit          inc;
      bit          irq_n;
      if (rst) begin
         model_reset();
         return;
      end
      wrap  = '0;
      imask = '0;
      irq_n = |m_ovf;
      for (int i = 0; i < 32; i++) begin
         if (impl(i)) begin
            imask[i] = 1'b1;
            inc = !m_inh[i] && ((i == 0) ? 1'b1 : (i == 2) ? m_retq : |(m_evt[i] & m_evq));
            v = m_cnt[i];
            if (we && a == 12'hB00 + 12'(i)) begin
               v = {v[63:32], wd} & wmask(i);
            end else if (we && a == 12'hB80 + 12'(i)) begin
               v = {wd, v[31:0]} & wmask(i);
            end else if (inc) begin
               if (v == wmask(i)) begin
                  v = '0;
                  wrap[i] = 1'b1;
               end else begin
                  v = v + 64'd1;
               end
            end
            m_cnt[i] = v;
            if (i >= 3 && we && a == 12'h320 + 12'(i)) m_evt[i] = wd[NE-1:0];
         end
      end
      if (we && a == 12'h320) m_inh = wd & imask;
      if (OvfEn) begin
         if (we && a == 12'h7C2) m_ovf = m_ovf & ~wd;
         m_ovf = m_ovf | wrap;
      end
      m_evq  = ev;
      m_retq = ret;
      m_irq  = irq_n;
   endfunction

   task automatic chk(input string nm, input logic [11:0] a, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s addr=%h got=%h want=%h t=%0t", nm, a, act, exp, $time);
      end
   endtask

   // Monitor: one expected response per cycle, compared mid-cycle
   always @(negedge clk_i) begin
      exp_t e;
      if (chk_v) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty t=%0t", $time);
         end else begin
            e = sb.pop_front();
            chk("csr_hit", e.addr, 32'(csr_hit_o), 32'(e.hit));
            if (e.hit) chk("csr_rdata", e.addr, csr_rdata_o, e.data);
            chk("irq_ovf", e.addr, 32'(irq_ovf_o), 32'(e.irq));
         end
      end
   end

   // Drive one cycle, queue the expected response, advance the model
   task automatic cyc(input bit rst, input bit we, input logic [11:0] a, input logic [31:0] wd,
                      input bit ret, input logic [NE-1:0] ev);
      exp_t e;
      rst_i       = rst;
      csr_we_i    = we;
      csr_addr_i  = a;
      csr_wdata_i = wd;
      instr_ret_i = ret;
      event_i     = ev;
      if (rst) model_reset();
      e.addr = a;
      exp_read(a, e.data, e.hit);
      e.irq = m_irq;
      sb.push_back(e);
      @(posedge clk_i);
      model_step(rst, we, a, wd, ret, ev);
      #1;
   endtask

   task automatic rd(input logic [11:0] a);
      cyc(1'b0, 1'b0, a, 32'h0, 1'b0, '0);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      cyc(1'b0, 1'b1, a, d, 1'b0, '0);
   endtask

   initial begin
      logic [11:0] ra;
      logic [31:0] rd_val;
      bit          rwe;
      bit          rrst;

      model_reset();
      @(posedge clk_i);
      #1;
      chk_v = 1'b1;

      // Reset, then idle
      repeat (3) cyc(1'b1, 1'b0, 12'hB00, 32'h0, 1'b0, '0);
      repeat (10) rd(12'hB00);
      rd(12'hB02); rd(12'hB03); rd(12'hB06); rd(12'hB83); rd(12'hB07);
      rd(12'h327); rd(12'h320); rd(12'h7C2); rd(12'hB01); rd(12'h321);

      // Event select: only event 2 counts
      wr(12'h323, 32'h4);
      repeat (5) cyc(1'b0, 1'b0, 12'hB03, 32'h0, 1'b0, 16'h0004);
      rd(12'hB03); rd(12'hB03);
      repeat (4) cyc(1'b0, 1'b0, 12'hB03, 32'h0, 1'b0, 16'h0002);
      rd(12'hB03); rd(12'h323);

      // Inhibit mcycle and minstret while events keep flowing
      repeat (3) cyc(1'b0, 1'b0, 12'hB02, 32'h0, 1'b1, 16'h0004);
      cyc(1'b0, 1'b1, 12'h320, 32'h5, 1'b1, 16'h0004);
      for (int k = 0; k < 6; k++) begin
         ra = (k % 3 == 0) ? 12'hB00 : (k % 3 == 1) ? 12'hB02 : 12'hB03;
         cyc(1'b0, 1'b0, ra, 32'h0, 1'b1, 16'h0004);
      end
      rd(12'h320);
      wr(12'h320, 32'h0);
      rd(12'hB00);

      // Wrap at CounterWidth
      wr(12'hB83, 32'hFFFF_FFFF);
      wr(12'hB03, 32'hFFFF_FFFF);
      rd(12'hB83); rd(12'hB03);
      cyc(1'b0, 1'b0, 12'hB03, 32'h0, 1'b0, 16'h0004);
      rd(12'hB03); rd(12'h7C2); rd(12'hB83); rd(12'h7C2); rd(12'h7C2);

      // Write beats a same-cycle increment
      cyc(1'b0, 1'b0, 12'hB03, 32'h0, 1'b0, 16'h0004);
      wr(12'hB03, 32'h100);
      rd(12'hB03); rd(12'hB03);

      // W1C clears the overflow bit and the interrupt follows
      wr(12'h7C2, 32'h8);
      rd(12'h7C2); rd(12'h7C2); rd(12'h7C2);

      // Wrap and W1C in the same cycle: bit stays set
      wr(12'hB83, 32'hFF);
      wr(12'hB03, 32'hFFFF_FFFF);
      cyc(1'b0, 1'b0, 12'h7C2, 32'h0, 1'b0, 16'h0004);
      wr(12'h7C2, 32'h8);
      rd(12'h7C2); rd(12'h7C2);
      wr(12'h7C2, 32'hFFFF_FFFF);
      rd(12'h7C2); rd(12'h7C2);

      // Unimplemented slots, masks and upper event bits
      wr(12'hB07, 32'h55); rd(12'hB07);
      wr(12'h327, 32'hFFFF); rd(12'h327);
      wr(12'hB87, 32'h1234); rd(12'hB87);
      wr(12'h324, 32'hFFFF_FFFF); rd(12'h324);
      wr(12'h320, 32'hFFFF_FFFF); rd(12'h320); rd(12'hB00);
      wr(12'h320, 32'h0);

      // 64-bit mcycle wrap
      wr(12'hB80, 32'hFFFF_FFFF);
      wr(12'hB00, 32'hFFFF_FFF0);
      repeat (20) rd(12'hB00);
      rd(12'hB80); rd(12'h7C2); rd(12'h7C2);

      // Reset mid-count drops the pipelined event
      wr(12'h323, 32'h4);
      cyc(1'b0, 1'b0, 12'hB03, 32'h0, 1'b1, 16'h0004);
      cyc(1'b1, 1'b0, 12'hB03, 32'h0, 1'b0, '0);
      rd(12'hB03); rd(12'hB02); rd(12'hB00);

      // Random traffic
      for (int k = 0; k < 2000; k++) begin
         ra     = ADDRS[$urandom_range(0, 25)];
         rwe    = ($urandom_range(0, 5) == 0);
         rrst   = ($urandom_range(0, 799) == 0);
         rd_val = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : 32'($urandom());
         if (ra == 12'h320 && $urandom_range(0, 1) == 0) rd_val = rd_val & 32'h2;
         cyc(rrst, rwe, ra, rd_val, 1'($urandom_range(0, 1)), NE'($urandom()));
      end

      chk_v = 1'b0;
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
